imem_port_arbiter: RTL and testbench
====================================

Name: imem_port_arbiter

Overview:
Shares the single-port 16-bit instruction memory (256 words, byte address, word index = address[15:1], synchronous read) between two requesters: the CPU fetch unit (read-only) and the program loader (read/write). Requesters use valid/ready requests and buffered valid/ready responses. One transaction is outstanding at a time. The block sits between the fetch/loader logic and the memory bank, and owns every memory-port signal.

Parameters:
MEM_WORDS, 256, memory depth in 16-bit words; word index must be < MEM_WORDS.
LOADER_PRIO, 0, 0 = round-robin between requesters; 1 = loader always wins ties.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
f_req_valid  in  1  fetch read request.
f_req_addr  in  16  fetch byte address.
f_req_ready  out  1  fetch request accepted this cycle.
f_rsp_valid  out  1  fetch response held.
f_rsp_data  out  16  fetch read data.
f_rsp_err  out  1  fetch address out of range.
f_rsp_ready  in  1  fetch consumes response.
f_kill  in  1  discard the outstanding fetch response (branch redirect).
l_req_valid  in  1  loader request.
l_req_we  in  1  1 = write, 0 = read.
l_req_addr  in  16  loader byte address.
l_req_wdata  in  16  loader write data.
l_req_ready  out  1  loader request accepted this cycle.
l_rsp_valid  out  1  loader response held.
l_rsp_data  out  16  read data; 16'h0000 for writes.
l_rsp_err  out  1  loader address out of range.
l_rsp_ready  in  1  loader consumes response.
mem_en  out  1  memory access strobe.
mem_we  out  1  memory write enable.
mem_addr  out  16  byte address to memory.
mem_wdata  out  16  memory write data.
mem_rdata  in  16  read data, valid the cycle after mem_en.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP.
- Reset (asynchronous): state = IDLE; last_grant = loader, so fetch wins the first tie.
- Reset clears all rsp_valid, rsp_err, mem_en and mem_we; it zeroes all rsp_data, mem_addr and mem_wdata.
- IDLE: pick a requester.
  - Only one valid: that one is granted.
  - Both valid and LOADER_PRIO=0: grant the requester that is not last_grant.
  - Both valid and LOADER_PRIO=1: grant the loader.
  - The granted req_ready is combinationally 1 in IDLE only. The other req_ready is 0.
  - On handshake, latch owner, addr, we (fetch always 0), wdata; update last_grant; go to ISSUE.
- Error check: err = (addr[15:1] >= MEM_WORDS), latched at accept.
- ISSUE: drive mem_en=1, mem_we=latched we, mem_addr, mem_wdata from the latch. If err, mem_en=0 and mem_we=0. Go to WAIT.
- WAIT: capture the response into the buffer and go to RESP.
  - Read without error: data = mem_rdata.
  - Write, or any error: data = 16'h0000.
- RESP: the owner's rsp_valid=1 with data/err stable until rsp_ready; on rsp_ready return to IDLE.
  - The non-owner's rsp_valid stays 0.
- Timing:
  - Accept edge to rsp_valid high: 3 cycles.
  - Minimum spacing between accepts: 4 cycles.
  - mem_en is exactly one cycle per non-error transaction.
- f_kill: applies to a fetch-owned transaction in ISSUE, WAIT or RESP (sampled each cycle).
  - The memory access still completes.
  - A kill flag is set; on reaching or sitting in RESP, the response is dropped: f_rsp_valid forced 0, return to IDLE next cycle.
  - f_kill has no effect on loader transactions or in IDLE.
- Request held while another is outstanding: req_ready stays 0; the requester must hold valid and address stable.
- Reset mid-transaction: the transaction is abandoned and no response is produced. A write already strobed in ISSUE has already happened.

Decomposition:
- Package imem_arb_pkg holds:
  - the state encoding (IDLE/ISSUE/WAIT/RESP);
  - owner encoding (OWN_FETCH=0, OWN_LOADER=1);
  - the reset value of last_grant;
  - WORD_IDX_MSB=15, WORD_IDX_LSB=1.
- One sub-module: imem_rr_pick, a combinational 2-way picker taking valid[1:0], last_grant and LOADER_PRIO, returning a grant one-hot.

Test Plan:
- Loader write addr 16'h0004 data 16'hBEEF, then fetch read 16'h0004 -> mem_en one cycle with mem_we=1 and mem_addr 16'h0004; fetch read returns f_rsp_data 16'hBEEF, f_rsp_err 0, 3 cycles after accept.
- Both valid every cycle, LOADER_PRIO=0 -> grants alternate F,L,F,L starting with fetch after reset; LOADER_PRIO=1 -> loader granted 4 times running.
- Fetch read addr 16'h0200 (word 256) -> f_rsp_err=1, data 16'h0000, mem_en never asserted.
- Fetch in WAIT with f_kill=1 -> f_rsp_valid stays 0; next loader request accepted 2 cycles later.
- f_rsp_ready held 0 for 5 cycles -> f_rsp_valid and data stable throughout; l_req_ready stays 0; loader accepted the cycle after IDLE is re-entered.
- rst pulsed while in WAIT -> all outputs zero immediately (asynchronous); no response after release; next fetch is granted first.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory port arbiter.
// Covers state/owner encodings, the reset grant history and the word-index range check.
package imem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_FETCH  = 1'b0,
    OWN_LOADER = 1'b1
  } owner_e;

  // Loader counts as the last winner out of reset, so fetch wins the first tie.
  localparam owner_e LAST_GRANT_RST = OWN_LOADER;

  localparam int WORD_IDX_MSB = 15;
  localparam int WORD_IDX_LSB = 1;

  function automatic logic addr_out_of_range(input logic [15:0] addr, input int mem_words);
    return 32'(addr[WORD_IDX_MSB:WORD_IDX_LSB]) >= mem_words;
  endfunction

endpackage

// File: rtl/imem_rr_pick.sv
// Combinational two-way picker: bit 0 = fetch, bit 1 = loader.
// Returns a one-hot grant, either round-robin on last_grant or loader-priority.
module imem_rr_pick
  import imem_arb_pkg::*;
#(
  parameter bit LOADER_PRIO = 1'b0
) (
  input  logic [1:0] valid,
  input  owner_e     last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11: begin
        if (LOADER_PRIO || (last_grant == OWN_FETCH)) grant = 2'b10;
        else                                          grant = 2'b01;
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-port instruction memory between CPU fetch and the program loader.
// One transaction in flight; memory-port signals are registered and loaded at accept.
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int MEM_WORDS   = 256,
  parameter bit LOADER_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req_valid,
  input  logic [15:0] f_req_addr,
  output logic        f_req_ready,
  output logic        f_rsp_valid,
  output logic [15:0] f_rsp_data,
  output logic        f_rsp_err,
  input  logic        f_rsp_ready,
  input  logic        f_kill,
  input  logic        l_req_valid,
  input  logic        l_req_we,
  input  logic [15:0] l_req_addr,
  input  logic [15:0] l_req_wdata,
  output logic        l_req_ready,
  output logic        l_rsp_valid,
  output logic [15:0] l_rsp_data,
  output logic        l_rsp_err,
  input  logic        l_rsp_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  owner_e      last_grant_q, last_grant_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic        kill_q, kill_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;

  logic [1:0]  grant;
  logic        fetch_kill;
  logic        kill_now;
  logic        f_show;
  logic        l_show;

  imem_rr_pick #(
    .LOADER_PRIO (LOADER_PRIO)
  ) u_pick (
    .valid      ({l_req_valid, f_req_valid}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign fetch_kill = f_kill && (owner_q == OWN_FETCH);
  assign kill_now   = kill_q || fetch_kill;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    err_d        = err_q;
    kill_d       = kill_q;
    rsp_data_d   = rsp_data_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    f_req_ready  = 1'b0;
    l_req_ready  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        f_req_ready = grant[0];
        l_req_ready = grant[1];
        if (grant[0]) begin
          owner_d     = OWN_FETCH;
          we_d        = 1'b0;
          mem_addr_d  = f_req_addr;
          mem_wdata_d = 16'h0000;
          err_d       = addr_out_of_range(f_req_addr, MEM_WORDS);
        end else if (grant[1]) begin
          owner_d     = OWN_LOADER;
          we_d        = l_req_we;
          mem_addr_d  = l_req_addr;
          mem_wdata_d = l_req_wdata;
          err_d       = addr_out_of_range(l_req_addr, MEM_WORDS);
        end
        if (grant != 2'b00) begin
          // The strobe is registered here so it is high for exactly the ISSUE cycle.
          last_grant_d = owner_d;
          mem_en_d     = !err_d;
          mem_we_d     = we_d && !err_d;
          kill_d       = 1'b0;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        kill_d  = kill_q || fetch_kill;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        kill_d     = kill_q || fetch_kill;
        rsp_data_d = (we_q || err_q) ? 16'h0000 : mem_rdata;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (kill_now) begin
          state_d = ST_IDLE;
        end else if ((owner_q == OWN_FETCH) ? f_rsp_ready : l_rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_FETCH;
      last_grant_q <= LAST_GRANT_RST;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      kill_q       <= 1'b0;
      rsp_data_q   <= 16'h0000;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 16'h0000;
      mem_wdata_q  <= 16'h0000;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      err_q        <= err_d;
      kill_q       <= kill_d;
      rsp_data_q   <= rsp_data_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign f_show = (state_q == ST_RESP) && (owner_q == OWN_FETCH) && !kill_now;
  assign l_show = (state_q == ST_RESP) && (owner_q == OWN_LOADER);

  assign f_rsp_valid = f_show;
  assign f_rsp_data  = f_show ? rsp_data_q : 16'h0000;
  assign f_rsp_err   = f_show && err_q;
  assign l_rsp_valid = l_show;
  assign l_rsp_data  = l_show ? rsp_data_q : 16'h0000;
  assign l_rsp_err   = l_show && err_q;

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench: transaction-level reference model (per-transaction cycle count,
// expected-memory array) compared every cycle against the arbiter, plus directed scenarios.
module tb_imem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req_valid, f_req_ready, f_rsp_valid, f_rsp_err, f_rsp_ready, f_kill;
  logic [15:0] f_req_addr, f_rsp_data;
  logic        l_req_valid, l_req_we, l_req_ready, l_rsp_valid, l_rsp_err, l_rsp_ready;
  logic [15:0] l_req_addr, l_req_wdata, l_rsp_data;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic        p_f_req_ready, p_f_rsp_valid, p_f_rsp_err;
  logic        p_l_req_ready, p_l_rsp_valid, p_l_rsp_err;
  logic [15:0] p_f_rsp_data, p_l_rsp_data;
  logic        p_mem_en, p_mem_we;
  logic [15:0] p_mem_addr, p_mem_wdata;

  always #5 clk = ~clk;

  imem_port_arbiter #(.MEM_WORDS(256), .LOADER_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(f_req_ready),
    .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data), .f_rsp_err(f_rsp_err),
    .f_rsp_ready(f_rsp_ready), .f_kill(f_kill),
    .l_req_valid(l_req_valid), .l_req_we(l_req_we), .l_req_addr(l_req_addr),
    .l_req_wdata(l_req_wdata), .l_req_ready(l_req_ready),
    .l_rsp_valid(l_rsp_valid), .l_rsp_data(l_rsp_data), .l_rsp_err(l_rsp_err),
    .l_rsp_ready(l_rsp_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Loader-priority instance: both requesters always valid, responses always consumed.
  imem_port_arbiter #(.MEM_WORDS(256), .LOADER_PRIO(1'b1)) dut_p (
    .clk(clk), .rst(rst),
    .f_req_valid(1'b1), .f_req_addr(16'h0002), .f_req_ready(p_f_req_ready),
    .f_rsp_valid(p_f_rsp_valid), .f_rsp_data(p_f_rsp_data), .f_rsp_err(p_f_rsp_err),
    .f_rsp_ready(1'b1), .f_kill(1'b0),
    .l_req_valid(1'b1), .l_req_we(1'b0), .l_req_addr(16'h0006),
    .l_req_wdata(16'h0000), .l_req_ready(p_l_req_ready),
    .l_rsp_valid(p_l_rsp_valid), .l_rsp_data(p_l_rsp_data), .l_rsp_err(p_l_rsp_err),
    .l_rsp_ready(1'b1),
    .mem_en(p_mem_en), .mem_we(p_mem_we), .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata),
    .mem_rdata(16'h0000)
  );

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 40503 + 12345);
  endfunction

  // Memory bank: synchronous read, written on mem_en & mem_we.
  logic        tb_init;
  logic [15:0] env_mem [256];
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= init_val(i);
      mem_rdata <= 16'h0000;
    end else if (mem_en) begin
      if (mem_we) env_mem[mem_addr[8:1]] <= mem_wdata;
      mem_rdata <= env_mem[mem_addr[8:1]];
    end
  end

  int mem_en_cnt = 0;
  always @(negedge clk) if (mem_en === 1'b1) mem_en_cnt++;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: one transaction, tracked by cycles since accept (1 = memory strobe cycle).
  logic [15:0] ref_mem [256];
  bit          m_busy, m_own, m_we, m_err, m_killed, m_last;
  int          m_k;
  logic [15:0] m_addr, m_wdata, m_data;
  bit          f_acc, l_acc;
  int          p_seen = 0;

  task automatic model_reset();
    m_busy = 0; m_killed = 0; m_last = 1'b1; m_k = 0;
  endtask

  task automatic step();
    bit ef, el, exp_en, in_resp, kill_now, exp_fv, exp_lv;
    logic [15:0] a;
    f_acc = 0; l_acc = 0;
    #1;
    ef = 0; el = 0;
    if (!m_busy) begin
      if (f_req_valid && l_req_valid) begin
        if (m_last) ef = 1; else el = 1;
      end else begin
        ef = f_req_valid; el = l_req_valid;
      end
    end
    chk("f_req_ready", f_req_ready, ef);
    chk("l_req_ready", l_req_ready, el);
    exp_en = m_busy && (m_k == 1) && !m_err;
    chk("mem_en", mem_en, exp_en);
    chk("mem_we", mem_we, exp_en && m_we);
    if (exp_en) begin
      chk("mem_addr", mem_addr, m_addr);
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
    in_resp  = m_busy && (m_k >= 3);
    kill_now = m_busy && !m_own && (m_killed || f_kill);
    exp_fv   = in_resp && !m_own && !kill_now;
    exp_lv   = in_resp && m_own;
    chk("f_rsp_valid", f_rsp_valid, exp_fv);
    chk("l_rsp_valid", l_rsp_valid, exp_lv);
    if (exp_fv) begin
      chk("f_rsp_data", f_rsp_data, m_data);
      chk("f_rsp_err", f_rsp_err, m_err);
    end
    if (exp_lv) begin
      chk("l_rsp_data", l_rsp_data, m_data);
      chk("l_rsp_err", l_rsp_err, m_err);
    end
    if ((p_f_req_ready || p_l_req_ready) && p_seen < 6) begin
      chk("prio_loader_grant", {p_f_req_ready, p_l_req_ready}, 2'b01);
      p_seen++;
    end
    @(posedge clk);
    if (!m_busy) begin
      if (ef || el) begin
        a        = el ? l_req_addr : f_req_addr;
        m_own    = el;
        m_addr   = a;
        m_we     = el && l_req_we;
        m_wdata  = el ? l_req_wdata : 16'h0000;
        m_err    = (a >> 1) >= 256;
        m_data   = (m_err || m_we) ? 16'h0000 : ref_mem[a[8:1]];
        if (m_we && !m_err) ref_mem[a[8:1]] = m_wdata;
        m_last   = m_own;
        m_busy   = 1; m_k = 1; m_killed = 0;
        f_acc    = ef; l_acc = el;
      end
    end else if (m_k >= 3) begin
      if (kill_now || (m_own ? l_rsp_ready : f_rsp_ready)) m_busy = 0;
    end else begin
      if (!m_own && f_kill) m_killed = 1;
      m_k++;
    end
    #1;
  endtask

  task automatic issue(input bit is_l, input bit we, input logic [15:0] addr,
                       input logic [15:0] wdata, output int lat);
    int n;
    if (is_l) begin
      l_req_valid = 1; l_req_we = we; l_req_addr = addr; l_req_wdata = wdata;
    end else begin
      f_req_valid = 1; f_req_addr = addr;
    end
    n = 0;
    do begin step(); n++; end while (!(f_acc || l_acc) && n < 20);
    if (!(f_acc || l_acc)) chk("accept_timeout", 0, 1);
    f_req_valid = 0; l_req_valid = 0;
    lat = 1;
    while (!(is_l ? l_rsp_valid : f_rsp_valid) && lat < 20) begin step(); lat++; end
    n = 0;
    while (m_busy && n < 20) begin step(); n++; end
    if (m_busy) chk("drain_timeout", 0, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rsp_valid"}, {f_rsp_valid, l_rsp_valid}, 2'b00);
    chk({tag, "_rsp_err"}, {f_rsp_err, l_rsp_err}, 2'b00);
    chk({tag, "_rsp_data"}, {f_rsp_data, l_rsp_data}, 32'h0);
    chk({tag, "_mem_ctl"}, {mem_en, mem_we}, 2'b00);
    chk({tag, "_mem_addr"}, mem_addr, 16'h0000);
    chk({tag, "_mem_wdata"}, mem_wdata, 16'h0000);
  endtask

  initial begin
    int lat, n, cnt0;
    int seq [4];
    logic [15:0] d0;
    rst = 1; tb_init = 1;
    f_req_valid = 0; f_req_addr = 0; f_rsp_ready = 1; f_kill = 0;
    l_req_valid = 0; l_req_we = 0; l_req_addr = 0; l_req_wdata = 0; l_rsp_ready = 1;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    tb_init = 0; rst = 0;

    // Round-robin with both requesters valid every cycle, starting from reset.
    f_req_valid = 1; f_req_addr = 16'h0002;
    l_req_valid = 1; l_req_we = 0; l_req_addr = 16'h0006;
    n = 0; cnt0 = 0;
    while (n < 4 && cnt0 < 40) begin
      step(); cnt0++;
      if (f_acc) begin seq[n] = 0; n++; end
      else if (l_acc) begin seq[n] = 1; n++; end
    end
    f_req_valid = 0; l_req_valid = 0;
    chk("rr_grant_count", n, 4);
    for (int i = 0; i < 4; i++) chk("rr_grant_order", seq[i], i % 2);
    while (m_busy && cnt0 < 60) begin step(); cnt0++; end

    // Loader write then fetch read-back.
    cnt0 = mem_en_cnt;
    issue(1, 1, 16'h0004, 16'hBEEF, lat);
    chk("wr_mem_en_cycles", mem_en_cnt - cnt0, 1);
    chk("wr_env_mem", env_mem[2], 16'hBEEF);
    issue(0, 0, 16'h0004, 16'h0000, lat);
    chk("rd_latency", lat, 3);

    // Out-of-range fetch: error response, no memory strobe.
    cnt0 = mem_en_cnt;
    issue(0, 0, 16'h0200, 16'h0000, lat);
    chk("err_mem_en_cycles", mem_en_cnt - cnt0, 0);
    chk("err_latency", lat, 3);

    // Kill while in WAIT; loader waiting behind it.
    f_req_valid = 1; f_req_addr = 16'h0010;
    n = 0;
    do begin step(); n++; end while (!f_acc && n < 20);
    f_req_valid = 0;
    step();
    f_kill = 1; l_req_valid = 1; l_req_we = 0; l_req_addr = 16'h0008;
    step();
    f_kill = 0;
    n = 0;
    do begin step(); n++; end while (!l_acc && n < 20);
    chk("kill_to_loader_accept", n, 2);
    l_req_valid = 0;
    n = 0;
    while (m_busy && n < 20) begin step(); n++; end

    // Fetch response stalled for 5 cycles with the loader waiting.
    f_rsp_ready = 0;
    f_req_valid = 1; f_req_addr = 16'h0004;
    n = 0;
    do begin step(); n++; end while (!f_acc && n < 20);
    f_req_valid = 0;
    l_req_valid = 1; l_req_we = 0; l_req_addr = 16'h000A;
    step(); step();
    for (int i = 0; i < 5; i++) begin
      chk("stall_f_valid", f_rsp_valid, 1);
      chk("stall_f_data", f_rsp_data, 16'hBEEF);
      step();
      chk("stall_l_acc", l_acc, 0);
    end
    f_rsp_ready = 1;
    step();
    chk("stall_release_l_acc", l_acc, 0);
    step();
    chk("stall_l_accept_in_idle", l_acc, 1);
    l_req_valid = 0;
    n = 0;
    while (m_busy && n < 20) begin step(); n++; end

    // Asynchronous reset while a fetch sits in WAIT.
    f_req_valid = 1; f_req_addr = 16'h0020;
    n = 0;
    do begin step(); n++; end while (!f_acc && n < 20);
    f_req_valid = 0;
    step();
    #1 rst = 1;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    #1 rst = 0;
    model_reset();
    repeat (4) step();
    f_req_valid = 1; f_req_addr = 16'h0002;
    l_req_valid = 1; l_req_we = 0; l_req_addr = 16'h0006;
    step();
    chk("post_rst_fetch_first", f_acc, 1);
    f_req_valid = 0; l_req_valid = 0;
    n = 0;
    while (m_busy && n < 20) begin step(); n++; end

    // Randomized traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      if (!(f_req_valid && !f_acc && m_busy) && !(f_req_valid && !f_acc)) begin
        f_req_valid = ($urandom_range(0, 1) == 1);
        f_req_addr  = ($urandom_range(0, 9) == 0) ? 16'(16'h0200 + ($urandom_range(0, 255) << 1))
                                                  : 16'($urandom_range(0, 511));
      end
      if (f_acc) f_req_valid = 0;
      if (!(l_req_valid && !l_acc)) begin
        l_req_valid = ($urandom_range(0, 1) == 1);
        l_req_we    = ($urandom_range(0, 2) == 0);
        l_req_wdata = 16'($urandom);
        l_req_addr  = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(512, 65535))
                                                  : 16'($urandom_range(0, 511));
      end
      if (l_acc) l_req_valid = 0;
      f_kill      = ($urandom_range(0, 7) == 0);
      f_rsp_ready = ($urandom_range(0, 3) != 0);
      l_rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    f_req_valid = 0; l_req_valid = 0; f_kill = 0; f_rsp_ready = 1; l_rsp_ready = 1;
    n = 0;
    while (m_busy && n < 20) begin step(); n++; end
    chk("prio_grants_seen", p_seen, 6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
